// File: rtl/vga_pkg.sv
// Shared timing constants and decode helper for the VGA raster generator.
// Defaults describe 640x480@60 Hz with a 25 MHz pixel rate from a 50 MHz board clock.
package vga_pkg;

    localparam int DEF_PIX_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // True when val lies in the half-open window [lo, lo+len).
    function automatic logic is_in(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_clk_enable_div.sv
// Pixel-rate enable: tick marks the terminal count of the divider, ce is its
// registered copy and is high for one clk out of every DIV.
module clk_enable_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic ce
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div;

    assign tick = (div == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            ce  <= 1'b0;
        end else begin
            div <= tick ? '0 : div + DW'(1);
            ce  <= tick;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel counters plus registered sync/active/start decode,
// all stepping on the pixel-rate enable so they stay aligned with x/y.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_ce,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (HT > 1024 || VT > 1024 || PIX_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: totals must be <= 1024 and PIX_DIV >= 1");
    end

    logic       tick;
    logic       run;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] nh, nv;

    clk_enable_div #(.DIV(PIX_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .ce    (pix_ce)
    );

    // The first tick after reset presents (0,0) rather than advancing past it.
    always_comb begin
        nh = h_cnt;
        nv = v_cnt;
        if (run) begin
            if (h_cnt == 10'(HT - 1)) begin
                nh = '0;
                nv = (v_cnt == 10'(VT - 1)) ? '0 : v_cnt + 10'd1;
            end else begin
                nh = h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (tick) begin
            run         <= 1'b1;
            h_cnt       <= nh;
            v_cnt       <= nv;
            active      <= is_in(int'(nh), 0, H_ACTIVE) && is_in(int'(nv), 0, V_ACTIVE);
            hsync       <= is_in(int'(nh), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
            vsync       <= is_in(int'(nv), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
            line_start  <= (nh == '0);
            frame_start <= (nh == '0) && (nv == '0);
        end
    end

    assign x = h_cnt;
    assign y = v_cnt;

endmodule
